// File: rtl/dreq_pkg.sv
// Shared types and helpers for the data-memory request queue.
// dreq_t is sized for the widest supported configuration (ADDR_W <= 64,
// DATA_W <= 128); narrower instances zero-extend into it and the unused
// upper bits stay constant zero.
package dreq_pkg;

    localparam int DREQ_AW_MAX = 64;
    localparam int DREQ_DW_MAX = 128;
    localparam int DREQ_BW_MAX = DREQ_DW_MAX / 8;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_t;

    typedef struct packed {
        logic                   ren;
        logic                   wen;
        logic [DREQ_AW_MAX-1:0] addr;
        logic [DREQ_DW_MAX-1:0] wdata;
        logic [DREQ_BW_MAX-1:0] be;
    } dreq_t;

    // The reserved encoding 2'b11 behaves as a full-width access.
    function automatic size_t decode_size(input logic [1:0] raw);
        size_t s;
        case (raw)
            2'b00:   s = SZ_BYTE;
            2'b01:   s = SZ_HALF;
            default: s = SZ_WORD;
        endcase
        return s;
    endfunction

    // Byte and half stores are copied into every lane so that the cache can
    // pick up the right lane purely from the byte enables.
    function automatic logic [DREQ_DW_MAX-1:0] lane_replicate(
        input logic [DREQ_DW_MAX-1:0] data,
        input size_t                  sz
    );
        logic [DREQ_DW_MAX-1:0] r;
        r = data;
        case (sz)
            SZ_BYTE: for (int i = 0; i < DREQ_BW_MAX; i++) r[8*i +: 8] = data[7:0];
            SZ_HALF: for (int i = 0; i < DREQ_BW_MAX/2; i++) r[16*i +: 16] = data[15:0];
            default: r = data;
        endcase
        return r;
    endfunction

    // Size mask (1, 3 or bw ones) moved onto the addressed lanes.
    function automatic logic [DREQ_BW_MAX-1:0] make_be(
        input size_t       sz,
        input logic [7:0]  off,
        input int unsigned bw
    );
        logic [DREQ_BW_MAX-1:0] m;
        case (sz)
            SZ_BYTE: m = DREQ_BW_MAX'(1);
            SZ_HALF: m = DREQ_BW_MAX'(3);
            default: m = (DREQ_BW_MAX'(1) << bw) - DREQ_BW_MAX'(1);
        endcase
        return m << off;
    endfunction

    // An access is aligned when its byte offset is a multiple of its size;
    // a full-width access must therefore start at lane 0.
    function automatic logic is_aligned(input size_t sz, input logic [7:0] off);
        logic ok;
        case (sz)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~off[0];
            default: ok = (off == 8'd0);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dreq_fifo.sv
// DEPTH-entry register FIFO of dreq_t descriptors. The head entry is read
// straight out of storage (no read latency) and forced to zero when empty.
// A flush discards everything behind the head; the head itself survives
// unless it is popped in the same cycle.
module dreq_fifo
    import dreq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  dreq_t                  wr_req,
    output dreq_t                  head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    dreq_t          mem [DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic [CW-1:0]  cnt;
    logic           full_r;
    logic           empty_r;

    logic           do_pop;
    logic           do_push;
    logic [PW-1:0]  rd_ptr_nx;
    logic [PW-1:0]  wr_ptr_nx;
    logic [CW-1:0]  cnt_nx;

    // Next-state pointer and occupancy arithmetic, including flush-keep-head.
    always_comb begin
        do_pop    = pop && !empty_r;
        do_push   = push && !flush && (!full_r || do_pop);
        rd_ptr_nx = do_pop ? rd_ptr + PW'(1) : rd_ptr;
        wr_ptr_nx = wr_ptr;
        cnt_nx    = cnt;
        if (flush) begin
            if (!empty_r && !do_pop) begin
                cnt_nx    = CW'(1);
                wr_ptr_nx = rd_ptr + PW'(1);
            end else begin
                cnt_nx    = '0;
                wr_ptr_nx = rd_ptr_nx;
            end
        end else begin
            cnt_nx    = cnt + CW'(do_push) - CW'(do_pop);
            wr_ptr_nx = do_push ? wr_ptr + PW'(1) : wr_ptr;
        end
    end

    // Pointer, count and registered status flags.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            cnt     <= '0;
            full_r  <= 1'b0;
            empty_r <= 1'b1;
        end else begin
            rd_ptr  <= rd_ptr_nx;
            wr_ptr  <= wr_ptr_nx;
            cnt     <= cnt_nx;
            full_r  <= (cnt_nx == CW'(DEPTH));
            empty_r <= (cnt_nx == '0);
        end
    end

    // Entry storage; a push into a full queue only happens alongside a pop,
    // in which case the slot being overwritten is the departing head.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push) begin
            mem[wr_ptr] <= wr_req;
        end
    end

    // Head view, blanked while empty so stale entries never reach the cache.
    always_comb begin
        head = empty_r ? '0 : mem[rd_ptr];
    end

    assign full  = full_r;
    assign empty = empty_r;
    assign count = cnt;

endmodule

// File: rtl/data_request_queue.sv
// Data-memory request unit between the datapath and the data cache.
// Loads/stores are qualified by ihit, checked for alignment, formatted into
// lane-replicated store data and byte enables, and queued. The oldest entry
// is presented to the cache until dhit.
//
// Cache handshake: the head is valid when dREN or dWEN is high (queue not
// empty); dhit is the completion/ready strobe. A transfer happens on a clock
// edge where the head is valid and dhit is high; until then the head is held
// stable. dhit with no valid head is ignored.
module data_request_queue
    import dreq_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   ihit,
    input  logic                   enq_ren,
    input  logic                   enq_wen,
    input  logic [ADDR_W-1:0]      enq_addr,
    input  logic [DATA_W-1:0]      enq_wdata,
    input  logic [1:0]             enq_size,
    input  logic                   flush,
    input  logic                   dhit,
    output logic                   dREN,
    output logic                   dWEN,
    output logic [ADDR_W-1:0]      daddr,
    output logic [DATA_W-1:0]      dstore,
    output logic [DATA_W/8-1:0]    dbe,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   misalign_err,
    output logic                   timeout_err
);

    localparam int BW  = DATA_W / 8;
    localparam int OW  = $clog2(BW);
    localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    size_t          sz;
    logic [OW-1:0]  off;
    logic           attempt;
    logic           aligned;
    logic           pop;
    logic           accept;
    dreq_t          enq_req;
    dreq_t          head;
    logic           fifo_full;
    logic           fifo_empty;
    logic [WDW-1:0] wd_cnt;
    logic           unused_head;

    // Request qualification and descriptor formatting; a store wins over a
    // simultaneous load request.
    always_comb begin
        sz      = decode_size(enq_size);
        off     = enq_addr[OW-1:0];
        attempt = ihit && (enq_ren || enq_wen);
        aligned = is_aligned(sz, 8'(off));
        pop     = dhit && !fifo_empty;
        accept  = attempt && aligned && !flush && (!fifo_full || pop);

        enq_req       = '0;
        enq_req.ren   = enq_ren && !enq_wen;
        enq_req.wen   = enq_wen;
        enq_req.addr  = DREQ_AW_MAX'(enq_addr);
        enq_req.wdata = lane_replicate(DREQ_DW_MAX'(enq_wdata), sz);
        enq_req.be    = make_be(sz, 8'(off), BW);
    end

    dreq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK    (CLK),
        .nRST   (nRST),
        .push   (accept),
        .pop    (pop),
        .flush  (flush),
        .wr_req (enq_req),
        .head   (head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (count)
    );

    // Misalignment is reported for exactly the cycle after the rejected attempt.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= attempt && !aligned;
        end
    end

    // Watchdog: counts cycles the head waits for dhit; the error is sticky
    // until reset. The counter parks at TIMEOUT-1 once the error has fired.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else if (TIMEOUT == 0) begin
            wd_cnt      <= '0;
        end else if (pop || fifo_empty) begin
            wd_cnt      <= '0;
        end else if (wd_cnt == WDW'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
        end else begin
            wd_cnt      <= wd_cnt + WDW'(1);
        end
    end

    // Head presentation, narrowed from the shared descriptor width.
    always_comb begin
        dREN   = head.ren;
        dWEN   = head.wen;
        daddr  = head.addr[ADDR_W-1:0];
        dstore = head.wdata[DATA_W-1:0];
        dbe    = head.be[BW-1:0];
    end

    assign full        = fifo_full;
    assign empty       = fifo_empty;
    assign unused_head = ^head;

endmodule

// File: tb/tb_data_request_queue.sv
// Directed and randomized bench for data_request_queue (DATA_W=32, DEPTH=4,
// TIMEOUT=8) against a queue-based reference model.
module tb_data_request_queue;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        ihit = 1'b0;
    logic        enq_ren = 1'b0;
    logic        enq_wen = 1'b0;
    logic [31:0] enq_addr = '0;
    logic [31:0] enq_wdata = '0;
    logic [1:0]  enq_size = '0;
    logic        flush = 1'b0;
    logic        dhit = 1'b0;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [3:0]  dbe;
    logic        full;
    logic        empty;
    logic [2:0]  count;
    logic        misalign_err;
    logic        timeout_err;

    int n_cmp = 0;
    int n_bad = 0;

    // Clock / reset
    always #5 CLK = ~CLK;

    data_request_queue #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .ihit         (ihit),
        .enq_ren      (enq_ren),
        .enq_wen      (enq_wen),
        .enq_addr     (enq_addr),
        .enq_wdata    (enq_wdata),
        .enq_size     (enq_size),
        .flush        (flush),
        .dhit         (dhit),
        .dREN         (dREN),
        .dWEN         (dWEN),
        .daddr        (daddr),
        .dstore       (dstore),
        .dbe          (dbe),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .misalign_err (misalign_err),
        .timeout_err  (timeout_err)
    );

    // Reference model: expected queue contents plus error state
    typedef struct {
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } req_t;

    req_t mq[$];
    int   wait_cycles = 0;
    logic m_terr = 1'b0;
    logic m_mis = 1'b0;

    function automatic int size_bytes(input logic [1:0] sz);
        if (sz == 2'd0) return 1;
        if (sz == 2'd1) return 2;
        return 4;
    endfunction

    function automatic req_t build(input logic is_st, input logic [31:0] a,
                                   input logic [31:0] d, input logic [1:0] sz);
        req_t r;
        int   nb;
        int   mask;
        nb     = size_bytes(sz);
        r.ren  = !is_st;
        r.wen  = is_st;
        r.addr = a;
        if (nb == 1)      r.data = {4{d[7:0]}};
        else if (nb == 2) r.data = {2{d[15:0]}};
        else              r.data = d;
        mask = (1 << nb) - 1;
        r.be = 4'(mask << (a % 4));
        return r;
    endfunction

    task automatic model_edge();
        logic attempt;
        logic aligned;
        logic pre_valid;
        logic pop;
        logic room;
        int   nb;
        nb        = size_bytes(enq_size);
        attempt   = ihit && (enq_ren || enq_wen);
        aligned   = ((enq_addr % nb) == 0);
        pre_valid = (mq.size() > 0);
        pop       = dhit && pre_valid;
        room      = (mq.size() < DEPTH) || pop;
        if (pop) wait_cycles = 0;
        else if (pre_valid) begin
            wait_cycles++;
            if (wait_cycles >= TIMEOUT) m_terr = 1'b1;
        end else wait_cycles = 0;
        m_mis = attempt && !aligned;
        if (pop) void'(mq.pop_front());
        if (flush) begin
            while (mq.size() > (pop ? 0 : 1)) void'(mq.pop_back());
        end
        if (attempt && aligned && !flush && room)
            mq.push_back(build(enq_wen, enq_addr, enq_wdata, enq_size));
    endtask

    // Scoreboard comparison
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
            $error("%s differs", tag);
        end
    endtask

    task automatic check_outputs();
        req_t h;
        h.ren = 0; h.wen = 0; h.addr = '0; h.data = '0; h.be = '0;
        if (mq.size() > 0) h = mq[0];
        chk("dREN", dREN, h.ren);
        chk("dWEN", dWEN, h.wen);
        chk("daddr", daddr, h.addr);
        chk("dstore", dstore, h.data);
        chk("dbe", dbe, h.be);
        chk("count", count, mq.size());
        chk("full", full, mq.size() == DEPTH);
        chk("empty", empty, mq.size() == 0);
        chk("misalign_err", misalign_err, m_mis);
        chk("timeout_err", timeout_err, m_terr);
    endtask

    // Driver tasks
    task automatic step(input logic ih, input logic rn, input logic wn,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] sz, input logic fl, input logic dh);
        @(negedge CLK);
        ihit = ih; enq_ren = rn; enq_wen = wn; enq_addr = a;
        enq_wdata = d; enq_size = sz; flush = fl; dhit = dh;
        @(posedge CLK);
        model_edge();
        #1 check_outputs();
    endtask

    task automatic idle(input logic dh);
        step(0, 0, 0, 32'h0, 32'h0, 2'd0, 0, dh);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        ihit = 0; enq_ren = 0; enq_wen = 0; flush = 0; dhit = 0;
        #2 nRST = 1'b0;
        #1;
        mq.delete();
        wait_cycles = 0;
        m_terr = 1'b0;
        m_mis = 1'b0;
        check_outputs();
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    initial begin
        do_reset();

        // Word store, then completion
        step(1, 0, 1, 32'h100, 32'hDEADBEEF, 2'd2, 0, 0);
        chk("word_dWEN", dWEN, 1'b1);
        chk("word_daddr", daddr, 32'h100);
        chk("word_dbe", dbe, 4'b1111);
        chk("word_dstore", dstore, 32'hDEADBEEF);
        idle(1);
        chk("word_done_empty", empty, 1'b1);
        chk("word_done_dWEN", dWEN, 1'b0);

        // Byte store, then half load pushed while the store completes
        step(1, 0, 1, 32'h103, 32'h0000005A, 2'd0, 0, 0);
        chk("byte_dstore", dstore, 32'h5A5A5A5A);
        chk("byte_dbe", dbe, 4'b1000);
        step(1, 1, 0, 32'h102, 32'h0, 2'd1, 0, 1);
        chk("half_dbe", dbe, 4'b1100);
        chk("half_dREN", dREN, 1'b1);
        idle(1);

        // Misaligned half load
        step(1, 1, 0, 32'h101, 32'h0, 2'd1, 0, 0);
        chk("mis_pulse", misalign_err, 1'b1);
        chk("mis_count", count, 3'd0);
        idle(0);
        chk("mis_clear", misalign_err, 1'b0);

        // Fill to DEPTH, overflow dropped, then push+pop while full
        for (int i = 0; i < 5; i++) step(1, 1, 0, 32'h200 + 4*i, 32'h0, 2'd2, 0, 0);
        chk("fill_full", full, 1'b1);
        chk("fill_count", count, 3'd4);
        chk("fill_head", daddr, 32'h200);
        step(1, 1, 0, 32'h300, 32'h0, 2'd2, 0, 1);
        chk("pushpop_count", count, 3'd4);
        chk("pushpop_head", daddr, 32'h204);
        for (int i = 0; i < 4; i++) idle(1);
        chk("drain_empty", empty, 1'b1);

        // Flush keeps head; flush with dhit empties
        for (int i = 0; i < 3; i++) step(1, 0, 1, 32'h500 + 4*i, 32'h11 * (i + 1), 2'd2, 0, 0);
        step(0, 0, 0, 32'h0, 32'h0, 2'd0, 1, 0);
        chk("flush_count", count, 3'd1);
        chk("flush_head", daddr, 32'h500);
        step(1, 0, 1, 32'h600, 32'h77, 2'd2, 0, 0);
        step(1, 0, 1, 32'h604, 32'h88, 2'd2, 1, 1);
        chk("flush_dhit_empty", empty, 1'b1);

        // Watchdog
        do_reset();
        step(1, 1, 0, 32'h400, 32'h0, 2'd2, 0, 0);
        for (int i = 0; i < 7; i++) idle(0);
        chk("wd_not_yet", timeout_err, 1'b0);
        idle(0);
        chk("wd_fired", timeout_err, 1'b1);
        idle(1);
        chk("wd_sticky", timeout_err, 1'b1);
        do_reset();
        chk("wd_reset", timeout_err, 1'b0);

        // Randomized traffic with a mid-run reset
        for (int n = 0; n < 400; n++) begin
            if (n == 200) do_reset();
            step($urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 2) == 0,
                 32'h1000 + $urandom_range(0, 63),
                 $urandom,
                 2'($urandom_range(0, 3)),
                 $urandom_range(0, 15) == 0,
                 $urandom_range(0, 2) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
